dma_bus_arbiter: RTL and testbench
==================================

// Module: dma_bus_arbiter
// PURPOSE
// - Round-robin arbiter sharing one 32-bit memory-bus master port among NUM_PORTS DMA channel bus masters.
// - Sits between the DMA_channel bus ports and the system bus; replaces the fixed-priority port mux in the DMA top.
// - One transaction in flight at a time; fair rotation keeps a streaming channel from starving the others.
// PARAMETERS
// - NUM_PORTS       3     number of requesters, 2..8
// - TIMEOUT_CYCLES  1024  bus-ready watchdog limit; only used with DMA_ARB_TIMEOUT_EN
// PORTS
// - i_clock       in   1            system clock, rising edge
// - i_reset       in   1            asynchronous, active-high reset
// - i_rq_request  in   NUM_PORTS    per-port request, held until that port's o_rq_ready
// - i_rq_rw       in   NUM_PORTS    per-port direction, 1 = write
// - i_rq_address  in   NUM_PORTS*32 per-port byte address, port p at [p*32+:32]
// - i_rq_wdata    in   NUM_PORTS*32 per-port write data
// - i_rq_wmask    in   NUM_PORTS*4  per-port byte-enable mask
// - o_rq_ready    out  NUM_PORTS    one-cycle completion pulse, one-hot
// - o_rq_rdata    out  32           read data; valid while any o_rq_ready bit is high
// - o_grant       out  NUM_PORTS    one-hot owner of the current transaction, 0 when idle
// - o_timeout     out  1            one-cycle pulse, coincident with o_rq_ready, on watchdog abort
// - o_bus_rw / o_bus_request / o_bus_address[32] / o_bus_wdata[32] / o_bus_wmask[4]  out   bus master
// - i_bus_ready   in   1            bus completion pulse
// - i_bus_rdata   in   32           bus read data, valid with i_bus_ready
// BEHAVIOUR
// - Reset: all outputs 0. State IDLE. Rotation pointer last = NUM_PORTS-1, so port 0 wins first.
// - FSM IDLE -> BUS -> DONE -> IDLE. All outputs are registered.
// - IDLE: if any i_rq_request is set, grant the first requesting port scanning last+1, last+2, ... (mod NUM_PORTS).
//   - On that edge: latch rw, address, wdata and wmask onto o_bus_*; set o_bus_request=1 and o_grant.
//   - Set last = granted port; go to BUS.
// - BUS: hold all o_bus_* stable.
//   - On i_bus_ready: o_bus_request<=0, latch o_rq_rdata<=i_bus_rdata (reads) or 0 (writes), set o_rq_ready[grant]; go to DONE.
// - DONE: one cycle with o_rq_ready high. Next edge: o_rq_ready<=0, o_grant<=0; go to IDLE.
//   - The requester drops i_rq_request on the edge that samples o_rq_ready, so it is low again in IDLE.
// - Latency: request seen in IDLE -> o_bus_request high next cycle.
//   - i_bus_ready at cycle t -> o_rq_ready at t+1.
//   - Minimum 3 cycles per transaction; no back-to-back bus cycles without one idle.
// - Fairness: a port requesting continuously waits for at most NUM_PORTS-1 other transactions.
// - Simultaneous requests in IDLE: resolved by the rotation only; no fixed priority.
// - Port drops i_rq_request while in BUS (protocol violation): transaction completes normally and o_rq_ready still pulses.
// - New requests from other ports during BUS or DONE: wait; they are evaluated in the next IDLE.
// - i_bus_ready while in IDLE or DONE: ignored.
// - Reset mid-transaction: bus request withdrawn immediately (async). Owner gets no o_rq_ready; the bus must also be reset.
// CONFIGURATION
// - DMA_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entering BUS and increments each BUS cycle without i_bus_ready.
//   - When it reaches TIMEOUT_CYCLES-1: drop o_bus_request, o_rq_rdata<=32'hFFFF_FFFF, pulse o_rq_ready[grant] and o_timeout; go to DONE.
//   - i_bus_ready in the same cycle as expiry wins: normal completion, no o_timeout.
// - DMA_ARB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; o_timeout tied 0.
// TESTING
// - Reset, then port 1 reads 0x0000_1000 and the bus returns 0xCAFE_0001 two cycles after request:
//   - o_bus_request one cycle after i_rq_request; o_rq_ready=3'b010 with rdata 0xCAFE_0001 one cycle after i_bus_ready.
// - Ports 0, 1 and 2 all hold requests continuously for 6 transactions:
//   - Grant order 0,1,2,0,1,2; o_grant always one-hot; o_bus_request low one cycle between transactions.
// - Port 2 writes 0xA5A5_A5A5 with mask 4'b0011 to 0x0000_2004:
//   - o_bus_rw=1, address, data and mask held exactly until i_bus_ready; o_rq_rdata=0 during the ready pulse.
// - Only port 0 requests repeatedly:
//   - Served every transaction; while port 0 is in BUS, port 1 raises a request -> port 1 is granted next.
// - Assert i_reset while in BUS:
//   - All outputs 0 asynchronously; after release the first grant goes to port 0; a stray i_bus_ready afterwards is ignored.
// - Timeout with DMA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus never ready:
//   - o_rq_ready, o_timeout and rdata 0xFFFF_FFFF after 8 BUS cycles.
//   - Rerun with i_bus_ready on cycle 8 -> normal completion, o_timeout=0.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin arbiter sharing one 32-bit bus master port among NUM_PORTS DMA channels.
// Define DMA_ARB_TIMEOUT_EN to add a bus-ready watchdog that aborts after TIMEOUT_CYCLES.
module dma_bus_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_PORTS-1:0]      i_rq_request,
  input  logic [NUM_PORTS-1:0]      i_rq_rw,
  input  logic [NUM_PORTS*32-1:0]   i_rq_address,
  input  logic [NUM_PORTS*32-1:0]   i_rq_wdata,
  input  logic [NUM_PORTS*4-1:0]    i_rq_wmask,
  output logic [NUM_PORTS-1:0]      o_rq_ready,
  output logic [31:0]               o_rq_rdata,
  output logic [NUM_PORTS-1:0]      o_grant,
  output logic                      o_timeout,
  output logic                      o_bus_rw,
  output logic                      o_bus_request,
  output logic [31:0]               o_bus_address,
  output logic [31:0]               o_bus_wdata,
  output logic [3:0]                o_bus_wmask,
  input  logic                      i_bus_ready,
  input  logic [31:0]               i_bus_rdata
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, pick, idx;
  logic found, expire;
  logic [NUM_PORTS-1:0] grant_q, grant_d, ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] wmask_q, wmask_d;
  logic rw_q, rw_d, req_q, req_d, to_q, to_d;
`ifdef DMA_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign expire = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = (state_q == BUS) ? cnt_q + 16'd1 : 16'd0;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expire = 1'b0;
`endif
  // Scan starts just after the last winner, so the previous owner ranks lowest
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = IW'((int'(last_q) + k) % NUM_PORTS);
      if (!found && i_rq_request[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rw_d    = rw_q;
    req_d   = req_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = BUS;
        last_d  = pick;
        grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
        rw_d    = i_rq_rw[pick];
        addr_d  = i_rq_address[int'(pick)*32 +: 32];
        wdata_d = i_rq_wdata[int'(pick)*32 +: 32];
        wmask_d = i_rq_wmask[int'(pick)*4 +: 4];
        req_d   = 1'b1;
      end
      BUS: if (i_bus_ready || expire) begin
        state_d = DONE;
        req_d   = 1'b0;
        ready_d = grant_q;
        to_d    = !i_bus_ready;
        rdata_d = i_bus_ready ? (rw_q ? 32'd0 : i_bus_rdata) : 32'hFFFF_FFFF;
      end
      DONE: begin
        state_d = IDLE;
        ready_d = '0;
        grant_d = '0;
        rdata_d = '0;
        to_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_PORTS - 1);
      grant_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rw_q    <= 1'b0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rw_q    <= rw_d;
      req_q   <= req_d;
      to_q    <= to_d;
    end
  assign o_rq_ready    = ready_q;
  assign o_rq_rdata    = rdata_q;
  assign o_grant       = grant_q;
  assign o_timeout     = to_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_request = req_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_wmask   = wmask_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: scoreboard bench; stimulus queues expected completions, a negedge monitor checks them.
module tb_dma_bus_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] i_rq_request = '0, i_rq_rw = '0;
  logic [N*32-1:0] i_rq_address = '0, i_rq_wdata = '0;
  logic [N*4-1:0] i_rq_wmask = '0;
  logic i_bus_ready = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic [N-1:0] o_rq_ready, o_grant;
  logic [31:0] o_rq_rdata, o_bus_address, o_bus_wdata;
  logic [3:0] o_bus_wmask;
  logic o_timeout, o_bus_rw, o_bus_request;
  logic [108:0] all_out;
  int checks = 0, errors = 0;
  typedef struct packed {logic [N-1:0] ready; logic [31:0] rdata; logic to;} exp_t;
  exp_t q[$];

  dma_bus_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(8)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_rq_request(i_rq_request), .i_rq_rw(i_rq_rw), .i_rq_address(i_rq_address),
    .i_rq_wdata(i_rq_wdata), .i_rq_wmask(i_rq_wmask),
    .o_rq_ready(o_rq_ready), .o_rq_rdata(o_rq_rdata), .o_grant(o_grant), .o_timeout(o_timeout),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;
  assign all_out = {o_rq_ready, o_rq_rdata, o_grant, o_timeout, o_bus_rw, o_bus_request,
                    o_bus_address, o_bus_wdata, o_bus_wmask};

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] r, input logic [31:0] d, input logic t);
    exp_t e;
    e = {r, d, t};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_grant != '0) chk("grant_onehot", 128'($onehot(o_grant)), 128'd1);
    if (!rst && o_rq_ready != '0) begin
      if (q.size() == 0) chk("unexpected_ready", o_rq_ready, 0);
      else begin
        e = q.pop_front();
        chk("rq_ready", o_rq_ready, e.ready);
        chk("rq_rdata", o_rq_rdata, e.rdata);
        chk("timeout_flag", o_timeout, e.to);
      end
    end
  end

  task automatic set_port(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm);
    i_rq_rw[p] = rw;
    i_rq_address[p*32 +: 32] = a;
    i_rq_wdata[p*32 +: 32] = wd;
    i_rq_wmask[p*4 +: 4] = wm;
  endtask

  // Entered at the negedge where the grant is first visible; bus fields must hold until ready.
  task automatic serve(input int d, input logic [31:0] rd, input logic [68:0] eb, input logic [N-1:0] eg);
    for (int c = 0; c <= d; c++) begin
      chk("bus_hold", {o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask, o_grant},
          {1'b1, eb, eg});
      if (c < d) @(negedge clk);
    end
    push_exp(eg, eb[68] ? 32'd0 : rd, 1'b0);
    i_bus_ready = 1'b1;
    i_bus_rdata = rd;
    @(posedge clk);
    #1 i_bus_ready = 1'b0;
    i_bus_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && !o_bus_request; i++) @(negedge clk);
    chk("grant_wait", o_bus_request, 1);
  endtask

  task automatic xact(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input int d, input logic [31:0] rd);
    @(posedge clk);
    #1 set_port(p, rw, a, wd, wm);
    i_rq_request[p] = 1'b1;
    @(negedge clk);
    chk("req_latency", o_bus_request, 0);
    @(negedge clk);
    serve(d, rd, {rw, a, wd, wm}, N'(1) << p);
    @(posedge clk);
    #1 i_rq_request[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("reset_outputs", all_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // single read on port 1, bus answers two cycles after the request
    xact(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'hCAFE_0001);
    // write on port 2, rdata must read 0 during the ready pulse
    xact(2, 1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 3, 32'h1111_2222);
    // all three ports request continuously
    for (int p = 0; p < N; p++) set_port(p, p[0], 32'h100 * (p + 1), 32'h5000 + p, 4'(p + 1));
    @(posedge clk);
    #1 i_rq_request = '1;
    for (int i = 0; i < 6; i++) begin
      int p;
      p = i % N;
      wait_grant();
      serve(i % 2, 32'h7700 + i, {p[0], 32'(32'h100 * (p + 1)), 32'(32'h5000 + p), 4'(p + 1)}, N'(1) << p);
      @(negedge clk);
      chk("done_gap", {o_bus_request, o_grant}, {1'b0, N'(1) << p});
      @(posedge clk);
      if (i == 5) #1 i_rq_request = '0;
      @(negedge clk);
      chk("idle_gap", {o_bus_request, o_grant}, 0);
    end
    // port 0 alone is served every time
    xact(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 32'h0000_0001);
    xact(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h0000_0002);
    // port 1 arrives while port 0 owns the bus and wins the next round
    @(posedge clk);
    #1 set_port(0, 1'b0, 32'h0000_0048, 32'h0, 4'h0);
    i_rq_request[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    set_port(1, 1'b0, 32'h0000_0900, 32'h0, 4'h0);
    i_rq_request[1] = 1'b1;
    serve(2, 32'h0000_0003, {1'b0, 32'h0000_0048, 32'h0, 4'h0}, 3'b001);
    wait_grant();
    serve(1, 32'h0000_0004, {1'b0, 32'h0000_0900, 32'h0, 4'h0}, 3'b010);
    @(posedge clk);
    #1 i_rq_request = '0;
    // reset while port 2 owns the bus
    @(posedge clk);
    #1 set_port(2, 1'b0, 32'h0000_0A00, 32'h0, 4'h0);
    i_rq_request[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_grant", o_grant, 3'b100);
    #2 rst = 1'b1;
    #1 chk("async_reset", all_out, 0);
    i_rq_request = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    i_bus_ready = 1'b1;
    @(negedge clk);
    i_bus_ready = 1'b0;
    chk("stray_ready", all_out, 0);
    @(posedge clk);
    #1 set_port(0, 1'b0, 32'h0000_0B00, 32'h0, 4'h0);
    set_port(2, 1'b0, 32'h0000_0C00, 32'h0, 4'h0);
    i_rq_request = 3'b101;
    @(negedge clk);
    @(negedge clk);
    serve(0, 32'h0000_00B0, {1'b0, 32'h0000_0B00, 32'h0, 4'h0}, 3'b001);
    @(posedge clk);
    #1 i_rq_request = '0;
`ifdef DMA_ARB_TIMEOUT_EN
    @(posedge clk);
    #1 set_port(1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
    i_rq_request[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("to_grant", o_grant, 3'b010);
    repeat (7) @(negedge clk);
    chk("to_pending", {o_rq_ready, o_timeout, o_bus_request}, 5'b00001);
    push_exp(3'b010, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("to_pulse", {o_timeout, o_bus_request}, 2'b10);
    @(posedge clk);
    #1 i_rq_request = '0;
    xact(1, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 7, 32'h1234_5678);
`endif
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
